// File: rtl/wmaj_pkg.sv
// Shared constants for the weighted-majority trend detector and its config controller.
// Defaults here are the values the detector runs with until a packet commits.
package wmaj_pkg;
   localparam int N       = 4;
   localparam int WIDTH   = 4;
   localparam int SW      = WIDTH + N;
   localparam int TIMEOUT = 255;
   localparam int TW      = $clog2(TIMEOUT + 1);
   localparam int IW      = (N > 1) ? $clog2(N) : 1;

   localparam logic [7:0]    HDR     = 8'hA5;
   localparam logic [SW-1:0] THR_HI0 = SW'(8);
   localparam logic [SW-1:0] THR_LO0 = SW'(4);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WGT  = 3'd1;
   localparam logic [2:0] ST_THI  = 3'd2;
   localparam logic [2:0] ST_TLO  = 3'd3;
   localparam logic [2:0] ST_CHK  = 3'd4;
   localparam logic [2:0] ST_PEND = 3'd5;

   // Binary-decaying weights: the newest bit (weight 0) dominates.
   function automatic logic [N*WIDTH-1:0] default_weights();
      logic [N*WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < N; i++) begin
         w[i*WIDTH +: WIDTH] = WIDTH'(1 << (N - 1 - i));
      end
      return w;
   endfunction

   localparam logic [N*WIDTH-1:0] WGT0 = default_weights();
endpackage

// File: rtl/wmaj_cfg_rx.sv
// Config packet receiver: byte FSM, running XOR checksum, inter-byte timeout, shadow set.
// Holds the validated shadow set in PEND and raises commit_o on the first sample tick.
module wmaj_cfg_rx
   import wmaj_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 cfg_valid_i,
   input  logic [7:0]           cfg_data_i,
   input  logic                 sample_tick_i,
   output logic                 cfg_ready_o,
   output logic                 cfg_busy_o,
   output logic                 cfg_err_o,
   output logic                 commit_o,
   output logic [N*WIDTH-1:0]   shw_o,
   output logic [SW-1:0]        shi_o,
   output logic [SW-1:0]        slo_o
);
   logic [2:0]         state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [7:0]         chk_q, chk_d;
   logic [TW-1:0]      cnt_q, cnt_d;
   logic [N*WIDTH-1:0] shw_q, shw_d;
   logic [SW-1:0]      shi_q, shi_d, slo_q, slo_d;
   logic               err_q, err_d;
   logic               xfer;

   assign cfg_ready_o = (state_q != ST_PEND);
   assign cfg_busy_o  = (state_q != ST_IDLE);
   assign cfg_err_o   = err_q;
   assign commit_o    = (state_q == ST_PEND) && sample_tick_i;
   assign shw_o       = shw_q;
   assign shi_o       = shi_q;
   assign slo_o       = slo_q;
   assign xfer        = cfg_valid_i && cfg_ready_o;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      chk_d   = chk_q;
      cnt_d   = cnt_q;
      shw_d   = shw_q;
      shi_d   = shi_q;
      slo_d   = slo_q;
      err_d   = 1'b0;
      if (state_q inside {ST_WGT, ST_THI, ST_TLO, ST_CHK}) begin
         if (xfer) begin
            cnt_d = '0;
         end else if (cnt_q == TW'(TIMEOUT - 1)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            cnt_d   = '0;
            shw_d   = '0;
            shi_d   = '0;
            slo_d   = '0;
         end else begin
            cnt_d = cnt_q + TW'(1);
         end
      end
      if (xfer) begin
         case (state_q)
            ST_IDLE: begin
               if (cfg_data_i == HDR) begin
                  state_d = ST_WGT;
                  chk_d   = HDR;
                  idx_d   = '0;
                  cnt_d   = '0;
               end
            end
            ST_WGT: begin
               shw_d[idx_q*WIDTH +: WIDTH] = cfg_data_i[WIDTH-1:0];
               chk_d = chk_q ^ cfg_data_i;
               idx_d = idx_q + IW'(1);
               if (idx_q == IW'(N - 1)) state_d = ST_THI;
            end
            ST_THI: begin
               shi_d   = SW'(cfg_data_i);
               chk_d   = chk_q ^ cfg_data_i;
               state_d = ST_TLO;
            end
            ST_TLO: begin
               slo_d   = SW'(cfg_data_i);
               chk_d   = chk_q ^ cfg_data_i;
               state_d = ST_CHK;
            end
            ST_CHK: begin
               if ((cfg_data_i == chk_q) && (slo_q <= shi_q)) begin
                  state_d = ST_PEND;
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end
      if (commit_o) state_d = ST_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         chk_q   <= '0;
         cnt_q   <= '0;
         shw_q   <= '0;
         shi_q   <= '0;
         slo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         chk_q   <= chk_d;
         cnt_q   <= cnt_d;
         shw_q   <= shw_d;
         shi_q   <= shi_d;
         slo_q   <= slo_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: rtl/wmaj_cfg_ctrl.sv
// Config controller top: active weight/threshold registers updated atomically on commit.
// Actives are registered and change only at a committed sample tick or at reset.
module wmaj_cfg_ctrl
   import wmaj_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 cfg_valid_i,
   input  logic [7:0]           cfg_data_i,
   output logic                 cfg_ready_o,
   input  logic                 sample_tick_i,
   output logic [N*WIDTH-1:0]   weights_o,
   output logic [SW-1:0]        thr_hi_o,
   output logic [SW-1:0]        thr_lo_o,
   output logic                 cfg_busy_o,
   output logic                 cfg_done_o,
   output logic                 cfg_err_o,
   output logic [7:0]           cfg_gen_o
);
   logic [N*WIDTH-1:0] shw, w_q, w_d;
   logic [SW-1:0]      shi, slo, hi_q, hi_d, lo_q, lo_d;
   logic [7:0]         gen_q, gen_d;
   logic               done_q;
   logic               commit;

   wmaj_cfg_rx u_rx (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .cfg_valid_i   (cfg_valid_i),
      .cfg_data_i    (cfg_data_i),
      .sample_tick_i (sample_tick_i),
      .cfg_ready_o   (cfg_ready_o),
      .cfg_busy_o    (cfg_busy_o),
      .cfg_err_o     (cfg_err_o),
      .commit_o      (commit),
      .shw_o         (shw),
      .shi_o         (shi),
      .slo_o         (slo)
   );

   assign w_d   = commit ? shw : w_q;
   assign hi_d  = commit ? shi : hi_q;
   assign lo_d  = commit ? slo : lo_q;
   assign gen_d = commit ? gen_q + 8'd1 : gen_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         w_q    <= WGT0;
         hi_q   <= THR_HI0;
         lo_q   <= THR_LO0;
         gen_q  <= '0;
         done_q <= 1'b0;
      end else begin
         w_q    <= w_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         gen_q  <= gen_d;
         done_q <= commit;
      end
   end

   assign weights_o  = w_q;
   assign thr_hi_o   = hi_q;
   assign thr_lo_o   = lo_q;
   assign cfg_gen_o  = gen_q;
   assign cfg_done_o = done_q;
endmodule
